conv_channel_acc: RTL and testbench
===================================

CONV_CHANNEL_ACC -- requirements
Module: conv_channel_acc

Interface
REQ-001 Parameter KERNEL, default 3; kernel side, window = KERNEL*KERNEL taps (1/3/5/7).
REQ-002 Parameter N, default 4; signed data width per tap.
REQ-003 Parameter M, default 4; signed weight width per tap.
REQ-004 Parameter E, default 4; kernel-sum extension bits, at least clog2(KERNEL*KERNEL).
REQ-005 Parameter CH, default 4; input channels accumulated per output, at least 1.
REQ-006 Parameter BW, default 8; signed bias width.
REQ-007 Parameter OUT_W, default 12; signed output width.
REQ-008 Port clk, input, 1; sole clock, all state updates on its rising edge.
REQ-009 Port rst, input, 1; asynchronous, active-low reset.
REQ-010 Port clr, input, 1; synchronous abort of the current channel group.
REQ-011 Port en_in, input, 1; data2conv/w beat valid.
REQ-012 Port data2conv, input, KERNEL*KERNEL*N; tap i is bits [i*N +: N].
REQ-013 Port w, input, KERNEL*KERNEL*M; tap i is bits [i*M +: M].
REQ-014 Port bias, input, BW; added once per group and sampled with the group's first beat.
REQ-015 Port d_out, output, OUT_W; saturated group result.
REQ-016 Port en_out, output, 1; one-cycle pulse marking d_out valid.
REQ-017 Port sat, output, 1; asserted with en_out when the result was clipped.
REQ-018 Port ch_idx, output, clog2(CH) (minimum 1); index of the next beat within the group.

Function
REQ-019 All arithmetic is two's-complement signed and every extension is a sign extension.
REQ-020 Stage 1 registers the KERNEL*KERNEL products, each N+M bits, when en_in=1.
REQ-021 Stage 2 registers the kernel sum, N+M+E bits.
REQ-022 Stage 3 accumulator is ACC_W = N+M+E+clog2(CH)+1 bits and cannot overflow.
REQ-023 On the first beat of a group (ch_idx=0), the accumulator loads sext(bias)+sum.
REQ-024 On every other beat, the accumulator adds sum to its current value.
REQ-025 On beat CH-1, the saturated final value registers into d_out and en_out pulses.
REQ-026 Latency from the en_in of the last beat to en_out high is exactly 3 cycles.
REQ-027 Valid beats tag the pipeline; idle cycles (en_in=0) may occur anywhere, and ch_idx and the accumulator hold across them.
REQ-028 ch_idx increments on each beat accepted at stage 1 and wraps from CH-1 to 0.
REQ-029 Back-to-back groups are allowed with no dead cycles; with CH=1, every beat yields an output.
REQ-030 Saturation: a value above 2^(OUT_W-1)-1 outputs the maximum and a value below -2^(OUT_W-1) outputs the minimum, each with sat=1; otherwise sat=0.
REQ-031 clr=1 zeroes ch_idx, kills all in-flight beat tags and the accumulator, and no en_out results from beats accepted before clr.
REQ-032 clr and en_in together: clr wins and that beat is discarded.
REQ-033 d_out and sat hold their values between en_out pulses.

Reset
REQ-034 rst low immediately zeroes d_out, en_out, sat, ch_idx, the accumulator, all stage registers and all valid tags.
REQ-035 Reset asserted mid-group drops the partial group; after release, the first beat starts a new group at ch_idx=0.

Configuration
REQ-036 With CONV_ACC_RELU_EN defined, a negative final value outputs d_out=0 and sat=0, and ReLU is applied before saturation.
REQ-037 Without CONV_ACC_RELU_EN, negative results pass through saturation unchanged, and no ReLU logic is synthesised.

Structure
REQ-038 Package conv_pkg holds the clog2 function, the ACC_W and sum-width derivations, and the signed saturate function.
REQ-039 The kernel sum is a single instance of sub-module carry_save_adder (N=KERNEL*KERNEL, E, W=N+M), and no other sub-modules are used.

Verification (KERNEL=3, N=M=4, CH=4, BW=8, OUT_W=12)
REQ-040 Stimulus: all taps data=1, w=1, bias=0, 4 consecutive beats. Response: d_out=36, sat=0, en_out exactly 3 cycles after beat 4.
REQ-041 Stimulus: data=-8, w=-8, 4 beats. Response: raw value 2304, so d_out=2047 and sat=1.
REQ-042 Stimulus: data=1, w=-1, bias=0, 4 beats. Response: d_out=0 with CONV_ACC_RELU_EN, d_out=-36 without.
REQ-043 Stimulus: 2 beats of ones, clr, then 4 beats of ones. Response: exactly one en_out, with d_out=36.
REQ-044 Stimulus: rst low after beat 2, release, then 4 beats of ones with gaps. Response: outputs 0 during reset, then a single d_out=36.
REQ-045 Stimulus: CH=1, bias=5, ones on every cycle. Response: en_out every cycle from cycle 3 on, d_out=14, ch_idx constant 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared helpers for the convolution channel accumulator: width derivations and signed saturation.
package conv_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int sum_w(input int n, input int m, input int e);
    return n + m + e;
  endfunction

  // One guard bit on top of the channel growth so the group sum cannot wrap.
  function automatic int acc_w(input int n, input int m, input int e, input int ch);
    return n + m + e + clog2(ch) + 1;
  endfunction

  function automatic logic signed [63:0] sat_max(input int ow);
    return (64'sd1 <<< (ow - 1)) - 64'sd1;
  endfunction

  function automatic logic is_sat(input logic signed [63:0] v, input int ow);
    return (v > sat_max(ow)) || (v < -sat_max(ow) - 64'sd1);
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int ow);
    if (v > sat_max(ow)) return sat_max(ow);
    else if (v < -sat_max(ow) - 64'sd1) return -sat_max(ow) - 64'sd1;
    else return v;
  endfunction

endpackage

// File: rtl/carry_save_adder.sv
// Multi-operand signed adder: 3:2 compression of N sign-extended operands, one final carry-propagate add.
module carry_save_adder #(
  parameter int N = 9,
  parameter int E = 4,
  parameter int W = 8
) (
  input  logic [N*W-1:0] ops,
  output logic [W+E-1:0] sum
);
  localparam int SW = W + E;

  logic [SW-1:0] s, c, x;

  always_comb begin
    s = '0;
    c = '0;
    x = '0;
    for (int i = 0; i < N; i++) begin
      x = SW'($signed(ops[i*W +: W]));
      // Carries out of the MSB are dropped; the result is exact modulo 2^SW.
      {s, c} = {s ^ c ^ x, ((s & c) | (s & x) | (c & x)) << 1};
    end
    sum = s + c;
  end
endmodule

// File: rtl/conv_channel_acc.sv
// Three-stage conv MAC: tap products, kernel sum, per-group channel accumulation with saturation.
// Define CONV_ACC_RELU_EN to clamp negative group results to zero ahead of saturation.
module conv_channel_acc
  import conv_pkg::*;
#(
  parameter int KERNEL = 3,
  parameter int N      = 4,
  parameter int M      = 4,
  parameter int E      = 4,
  parameter int CH     = 4,
  parameter int BW     = 8,
  parameter int OUT_W  = 12,
  localparam int CIW   = (clog2(CH) < 1) ? 1 : clog2(CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en_in,
  input  logic [KERNEL*KERNEL*N-1:0] data2conv,
  input  logic [KERNEL*KERNEL*M-1:0] w,
  input  logic [BW-1:0]            bias,
  output logic [OUT_W-1:0]         d_out,
  output logic                     en_out,
  output logic                     sat,
  output logic [CIW-1:0]           ch_idx
);
  localparam int T     = KERNEL * KERNEL;
  localparam int PW    = N + M;
  localparam int SW    = sum_w(N, M, E);
  localparam int ACC_W = acc_w(N, M, E, CH);
  localparam logic [CIW-1:0] LAST = CIW'(CH - 1);

  logic                     beat;
  logic [T-1:0][PW-1:0]     prod_d, prod_q;
  logic [SW-1:0]            sum_d, sum_q;
  logic [1:0]               vld_pipe, first_pipe, last_pipe;
  logic [BW-1:0]            bias_s1, bias_s2;
  logic signed [ACC_W-1:0]  acc, acc_nxt, fin;

  assign beat = en_in & ~clr;

  for (genvar i = 0; i < T; i++) begin : g_tap
    logic signed [PW-1:0] dx, wx;
    assign dx        = PW'($signed(data2conv[i*N +: N]));
    assign wx        = PW'($signed(w[i*M +: M]));
    assign prod_d[i] = dx * wx;
  end

  carry_save_adder #(.N(T), .E(E), .W(PW)) u_csa (
    .ops (prod_q),
    .sum (sum_d)
  );

  // Stages 1-2 plus the group position; beat tags ride along with the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q     <= '0;
      sum_q      <= '0;
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
      bias_s1    <= '0;
      bias_s2    <= '0;
      ch_idx     <= '0;
    end else if (clr) begin
      vld_pipe <= '0;
      ch_idx   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], beat};
      if (beat) begin
        prod_q        <= prod_d;
        first_pipe[0] <= (ch_idx == '0);
        last_pipe[0]  <= (ch_idx == LAST);
        ch_idx        <= (ch_idx == LAST) ? '0 : ch_idx + 1'b1;
        if (ch_idx == '0) bias_s1 <= bias;
      end
      if (vld_pipe[0]) begin
        sum_q         <= sum_d;
        first_pipe[1] <= first_pipe[0];
        last_pipe[1]  <= last_pipe[0];
        bias_s2       <= bias_s1;
      end
    end
  end

  always_comb begin
    acc_nxt = acc + ACC_W'($signed(sum_q));
    if (first_pipe[1])
      acc_nxt = ACC_W'($signed(bias_s2)) + ACC_W'($signed(sum_q));
    fin = acc_nxt;
`ifdef CONV_ACC_RELU_EN
    if (acc_nxt[ACC_W-1]) fin = '0;
`endif
  end

  // Output registers load from the next accumulator value so the result lands with the last sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      d_out  <= '0;
      en_out <= 1'b0;
      sat    <= 1'b0;
    end else if (clr) begin
      acc    <= '0;
      en_out <= 1'b0;
    end else begin
      en_out <= vld_pipe[1] & last_pipe[1];
      if (vld_pipe[1]) begin
        acc <= acc_nxt;
        if (last_pipe[1]) begin
          d_out <= OUT_W'(saturate(64'(fin), OUT_W));
          sat   <= is_sat(64'(fin), OUT_W);
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_channel_acc.sv
// Randomized + directed bench for conv_channel_acc against a group-level arithmetic model.
module tb_conv_channel_acc;
  localparam int KERNEL = 3, N = 4, M = 4, E = 4, CH = 4, BW = 8, OUT_W = 12;
  localparam int T = KERNEL * KERNEL;

  logic clk = 1'b0, rst = 1'b0, clr = 1'b0, en_in = 1'b0;
  logic [T*N-1:0] data2conv = '0;
  logic [T*M-1:0] w = '0;
  logic [BW-1:0]  bias = '0;
  logic [OUT_W-1:0] d_out;
  logic en_out, sat;
  logic [1:0] ch_idx;

  logic clr1 = 1'b0, en1 = 1'b0;
  logic [T*N-1:0] data1 = {T{4'b0001}};
  logic [T*M-1:0] w1 = {T{4'b0001}};
  logic [BW-1:0]  bias1 = 8'd5;
  logic [OUT_W-1:0] d_out1;
  logic en_out1, sat1;
  logic [0:0] ch_idx1;

  conv_channel_acc #(.KERNEL(KERNEL), .N(N), .M(M), .E(E), .CH(CH), .BW(BW), .OUT_W(OUT_W)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .en_in(en_in), .data2conv(data2conv), .w(w), .bias(bias),
    .d_out(d_out), .en_out(en_out), .sat(sat), .ch_idx(ch_idx));

  conv_channel_acc #(.KERNEL(KERNEL), .N(N), .M(M), .E(E), .CH(1), .BW(BW), .OUT_W(OUT_W)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr1), .en_in(en1), .data2conv(data1), .w(w1), .bias(bias1),
    .d_out(d_out1), .en_out(en_out1), .sat(sat1), .ch_idx(ch_idx1));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, n_out = 0;
  longint cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: group arithmetic on plain integers, results queued with their due cycle.
  typedef struct { longint due; int d; bit s; } exp_t;
  exp_t   q[$];
  int     m_idx = 0, m_p = 0, last_d = 0, m_d = 0;
  bit     last_s = 1'b0, m_s = 1'b0;
  longint m_acc = 0;

  function automatic int dot();
    int s, a, b;
    s = 0;
    for (int i = 0; i < T; i++) begin
      a = $signed(data2conv[i*N +: N]);
      b = $signed(w[i*M +: M]);
      s += a * b;
    end
    return s;
  endfunction

  function automatic void mdl_sat(input longint v, output int d, output bit s);
`ifdef CONV_ACC_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > 2047) begin d = 2047; s = 1'b1; end
    else if (v < -2048) begin d = -2048; s = 1'b1; end
    else begin d = int'(v); s = 1'b0; end
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_idx = 0; m_acc = 0; q.delete();
    end else if (clr) begin
      m_idx = 0; m_acc = 0;
      while (q.size() > 0 && q[$].due >= cyc) void'(q.pop_back());
    end else if (en_in) begin
      m_p = dot();
      if (m_idx == 0) m_acc = longint'($signed(bias)) + m_p;
      else            m_acc = m_acc + m_p;
      if (m_idx == CH - 1) begin
        mdl_sat(m_acc, m_d, m_s);
        q.push_back('{cyc + 2, m_d, m_s});
      end
      m_idx = (m_idx + 1) % CH;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_d_out", longint'(d_out), 0);
      check("rst_en_out", en_out, 0);
      check("rst_sat", sat, 0);
      check("rst_ch_idx", ch_idx, 0);
      q.delete(); last_d = 0; last_s = 1'b0;
    end else begin
      check("ch_idx", ch_idx, m_idx);
      if (q.size() > 0 && q[0].due == cyc) begin
        check("en_out", en_out, 1);
        last_d = q[0].d; last_s = q[0].s;
        void'(q.pop_front());
      end else begin
        check("en_out_idle", en_out, 0);
      end
      check("d_out", longint'($signed(d_out)), last_d);
      check("sat", sat, last_s);
      if (en_out) n_out++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] dv, input logic [3:0] wv, input logic [7:0] b);
    data2conv = {T{dv}}; w = {T{wv}}; bias = b; en_in = 1'b1;
    @(posedge clk); #1;
    en_in = 1'b0;
  endtask

  task automatic group4(input logic [3:0] dv, input logic [3:0] wv, input logic [7:0] b);
    repeat (4) beat(dv, wv, b);
  endtask

  // Called right after the last beat: en_out must appear exactly on the third cycle.
  task automatic expect3(input string name, input int d, input bit s);
    @(negedge clk); check({name, "_lat1"}, en_out, 0);
    @(negedge clk); check({name, "_lat2"}, en_out, 0);
    @(negedge clk); check({name, "_en"}, en_out, 1);
    check({name, "_d"}, longint'($signed(d_out)), d);
    check({name, "_sat"}, sat, s);
    @(posedge clk); #1;
  endtask

  int n0;

  initial begin
    idle(3);
    rst = 1'b1;
    idle(1);

    group4(4'sd1, 4'sd1, 8'sd0);
    expect3("ones", 36, 1'b0);
    group4(-4'sd8, -4'sd8, 8'sd0);
    expect3("maxsat", 2047, 1'b1);
    group4(4'sd1, -4'sd1, 8'sd0);
`ifdef CONV_ACC_RELU_EN
    expect3("neg", 0, 1'b0);
`else
    expect3("neg", -36, 1'b0);
`endif
    group4(4'sd1, 4'sd1, -8'sd10);
    expect3("bias", 26, 1'b0);

    n0 = n_out;
    beat(4'sd1, 4'sd1, 8'sd0); beat(4'sd1, 4'sd1, 8'sd0);
    clr = 1'b1; idle(1); clr = 1'b0;
    group4(4'sd1, 4'sd1, 8'sd0);
    expect3("clr", 36, 1'b0);
    idle(4);
    check("clr_pulses", n_out - n0, 1);

    n0 = n_out;
    beat(4'sd1, 4'sd1, 8'sd0); beat(4'sd1, 4'sd1, 8'sd0);
    rst = 1'b0; idle(3); rst = 1'b1; idle(1);
    beat(4'sd1, 4'sd1, 8'sd0); idle(1);
    beat(4'sd1, 4'sd1, 8'sd0); idle(2);
    beat(4'sd1, 4'sd1, 8'sd0);
    beat(4'sd1, 4'sd1, 8'sd0);
    expect3("rst_mid", 36, 1'b0);
    idle(4);
    check("rst_pulses", n_out - n0, 1);

    for (int c = 0; c < 500; c++) begin
      clr   = ($urandom_range(0, 99) < 3);
      en_in = ($urandom_range(0, 99) < 70);
      bias  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        data2conv = {T{4'b1000}};
        w = ($urandom_range(0, 1) == 1) ? {T{4'b1000}} : {T{4'b0111}};
      end else begin
        for (int i = 0; i < T; i++) begin
          data2conv[i*N +: N] = 4'($urandom);
          w[i*M +: M]         = 4'($urandom);
        end
      end
      @(posedge clk); #1;
    end
    clr = 1'b0; en_in = 1'b0;
    idle(6);

    en1 = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("ch1_idx", ch_idx1, 0);
      if (c < 3) check("ch1_pre", en_out1, 0);
      else begin
        check("ch1_en", en_out1, 1);
        check("ch1_d", longint'($signed(d_out1)), 14);
        check("ch1_sat", sat1, 0);
      end
    end
    en1 = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
